// File: rtl/i2s_dac_tx.sv
// I2S master serialiser: packs processed 15-bit L/R samples into a 32-bit frame and shifts it out MSB-first to the codec.
// Latency: samples are captured on the BCLK falling edge where bit_cnt wraps to 0; the left MSB leaves one BCLK later.
// Backpressure: none; the codec is a slave that consumes one bit per BCLK. Optional MCLK output: define I2S_DAC_TX_MCLK_EN.
module i2s_dac_tx #(
  parameter int SAMPLE_W  = 15,
  parameter int BCLK_HALF = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] ldata,
  input  logic [SAMPLE_W-1:0] rdata,
  input  logic                exchan,
  input  logic                mix,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                frame_strobe,
  output logic                aud_xck
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic [4:0]       r_bit_cnt;
  logic             r_lrck;
  logic             r_dly_bit;
  logic [31:0]      r_shift;
  logic             r_strobe;
  logic             r_xck;

  logic             w_tick;
  logic             w_fall;
  logic             w_load;
  logic [4:0]       w_bit_nxt;

  // Samples widened by two bits so 3*a+b cannot overflow.
  logic signed [SAMPLE_W+1:0] w_ls;
  logic signed [SAMPLE_W+1:0] w_rs;
  logic signed [SAMPLE_W+1:0] w_lsum;
  logic signed [SAMPLE_W+1:0] w_rsum;
  logic signed [SAMPLE_W+1:0] w_lsel;
  logic signed [SAMPLE_W+1:0] w_rsel;
  logic [15:0]                w_lword;
  logic [15:0]                w_rword;

  assign w_tick    = (r_div_cnt == DIV_W'(BCLK_HALF - 1));
  assign w_fall    = w_tick && r_bclk;
  assign w_load    = w_fall && (r_bit_cnt == 5'd31);
  assign w_bit_nxt = r_bit_cnt + 5'd1;

  assign w_ls   = {{2{ldata[SAMPLE_W-1]}}, ldata};
  assign w_rs   = {{2{rdata[SAMPLE_W-1]}}, rdata};
  assign w_lsum = w_ls + w_ls + w_ls + w_rs;
  assign w_rsum = w_rs + w_rs + w_rs + w_ls;
  // Arithmetic shift rounds toward -inf; result always fits SAMPLE_W bits.
  assign w_lsel = mix ? (w_lsum >>> 2) : w_ls;
  assign w_rsel = mix ? (w_rsum >>> 2) : w_rs;
  // Left-justify the SAMPLE_W-bit result in a 16-bit word, zero LSBs below it.
  assign w_lword = 16'(w_lsel) << (16 - SAMPLE_W);
  assign w_rword = 16'(w_rsel) << (16 - SAMPLE_W);

  // BCLK divider: toggle every BCLK_HALF clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Frame sequencing on BCLK falling events: bit counter, LR clock, load/shift, data out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 5'd31;
      r_lrck    <= 1'b0;
      r_dly_bit <= 1'b0;
      r_shift   <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= w_load;
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= w_bit_nxt[4];
        // Output the MSB as it stood before this event; since the load lands
        // on bit 0, the left MSB appears on bit 1 (the I2S one-bit delay).
        r_dly_bit <= r_shift[31];
        if (w_load) begin
          r_shift <= exchan ? {w_rword, w_lword} : {w_lword, w_rword};
        end else begin
          r_shift <= {r_shift[30:0], 1'b0};
        end
      end
    end
  end

  // Codec master clock: clk/2 when enabled, otherwise held low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xck <= 1'b0;
    end else begin
`ifdef I2S_DAC_TX_MCLK_EN
      r_xck <= ~r_xck;
`else
      r_xck <= 1'b0;
`endif
    end
  end

  assign aud_bclk     = r_bclk;
  assign aud_daclrck  = r_lrck;
  assign aud_dacdat   = r_dly_bit;
  assign frame_strobe = r_strobe;
  assign aud_xck      = r_xck;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: random and directed sample pairs, scoreboard of expected 32-bit frames.
// A monitor rebuilds each frame from dacdat/daclrck sampled on BCLK rising edges and compares.
// Includes reset-release timing checks and a mid-frame reset.
module tb_i2s_dac_tx;
  localparam int SW   = 15;
  localparam int BH   = 9;
  localparam int FALL = 2 * BH;
  localparam int NF   = 24;
  localparam int RST_F = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] ldata = '0;
  logic [SW-1:0] rdata = '0;
  logic          exchan = 1'b0;
  logic          mix = 1'b0;
  logic          aud_bclk, aud_daclrck, aud_dacdat, frame_strobe, aud_xck;

  i2s_dac_tx #(.SAMPLE_W(SW), .BCLK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .ldata(ldata), .rdata(rdata), .exchan(exchan), .mix(mix),
    .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat),
    .frame_strobe(frame_strobe), .aud_xck(aud_xck)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  function automatic int to_int(input logic [SW-1:0] x);
    int v;
    v = int'(x);
    if (x[SW-1]) v = v - (1 << SW);
    return v;
  endfunction

  // Reference: mix with floor division by 4, then optional swap, then left-justify in 16 bits.
  function automatic logic [31:0] ref_frame(input logic [SW-1:0] l_in, input logic [SW-1:0] r_in,
                                            input logic mx, input logic ex);
    int l, r, a, b, t;
    logic [15:0] wa, wb;
    l = to_int(l_in);
    r = to_int(r_in);
    a = l;
    b = r;
    if (mx) begin
      a = (3 * l + r) >>> 2;
      b = (3 * r + l) >>> 2;
    end
    if (ex) begin
      t = a; a = b; b = t;
    end
    wa = 16'(a * (1 << (16 - SW)));
    wb = 16'(b * (1 << (16 - SW)));
    return {wa, wb};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int          pos = 0;
  bit          cur_valid = 0, prev_valid = 0;
  logic [31:0] cur_exp, cur_dat, cur_lr, prev_exp, prev_dat, prev_lr;
  logic        prev_bclk = 1'b0;
  int          frames_done = 0;
  int          xck_err = 0;
  logic        prev_xck = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      cur_valid  = 0;
      prev_valid = 0;
      pos        = 0;
    end else begin
`ifdef I2S_DAC_TX_MCLK_EN
      if (aud_xck == prev_xck) xck_err++;
`else
      if (aud_xck !== 1'b0) xck_err++;
`endif
      if (frame_strobe) begin
        prev_valid = cur_valid && (pos == 32);
        prev_exp   = cur_exp;
        prev_dat   = cur_dat;
        prev_lr    = cur_lr;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL exp_queue: frame load with no expected frame pending");
          cur_valid = 0;
        end else begin
          cur_exp   = exp_q.pop_front();
          cur_valid = 1;
        end
        pos     = 0;
        cur_dat = '0;
        cur_lr  = '0;
      end
      if (aud_bclk && !prev_bclk) begin
        if (pos == 0) begin
          if (prev_valid) begin
            prev_dat[0] = aud_dacdat;
            prev_lr[0]  = aud_daclrck;
            check("frame_data", prev_dat, prev_exp);
            check("frame_lrck", prev_lr, 32'h0001_FFFE);
            frames_done++;
            prev_valid = 0;
          end
        end else if (pos < 32) begin
          cur_dat[32-pos] = aud_dacdat;
          cur_lr[32-pos]  = aud_daclrck;
        end
        if (pos < 32) pos++;
      end
    end
    prev_bclk = aud_bclk;
    prev_xck  = aud_xck;
  end

  // ---------------- driver ----------------
  task automatic measure_release();
    int n, rise_at, strobe_at;
    logic lr;
    n = 0; rise_at = -1; strobe_at = -1; lr = 1'bx;
    while (n < 100 && strobe_at < 0) begin
      @(posedge clk); #1;
      n++;
      if (aud_bclk && rise_at < 0) rise_at = n;
      if (frame_strobe) begin
        strobe_at = n;
        lr = aud_daclrck;
      end
    end
    check("first_bclk_rise", rise_at, BH);
    check("first_strobe", strobe_at, FALL);
    check("lrck_at_load", {31'd0, lr}, 32'd0);
    if (strobe_at < 0) finish_run();
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    while (n < 2 * 32 * FALL) begin
      @(posedge clk); #1;
      n++;
      if (frame_strobe) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL strobe_timeout: no frame_strobe within %0d cycles", n);
    finish_run();
  endtask

  logic [SW-1:0] dir_l[6]  = '{15'h4000, 15'h4000, 15'h3FFF, 15'h3FFF, 15'h4000, 15'h3FFF};
  logic [SW-1:0] dir_r[6]  = '{15'h3FFF, 15'h3FFF, 15'h4000, 15'h3FFF, 15'h4000, 15'h4000};
  logic          dir_m[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic          dir_x[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0]   dir_e[6]  = '{32'h8000_7FFE, 32'h7FFE_8000, 32'h3FFE_BFFE,
                               32'h7FFE_7FFE, 32'h8000_8000, 32'hBFFE_3FFE};

  initial begin
    int d1, d2;
    rst    = 1'b1;
    ldata  = dir_l[0];
    rdata  = dir_r[0];
    mix    = dir_m[0];
    exchan = dir_x[0];
    exp_q.push_back(dir_e[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, aud_bclk, aud_daclrck, aud_dacdat, frame_strobe, aud_xck}, 32'd0);
    rst = 1'b0;
    measure_release();

    for (int f = 1; f < NF; f++) begin
      // Disturb the inputs early in the frame; the frame being sent must not change.
      d1 = $urandom_range(20, 8 * FALL + 5);
      repeat (d1) @(posedge clk);
      #1;
      ldata  = SW'($urandom);
      rdata  = SW'($urandom);
      mix    = 1'($urandom);
      exchan = 1'($urandom);
      d2 = $urandom_range(10, 100);
      repeat (d2) @(posedge clk);
      #1;
      if (f < 6) begin
        ldata  = dir_l[f];
        rdata  = dir_r[f];
        mix    = dir_m[f];
        exchan = dir_x[f];
        exp_q.push_back(dir_e[f]);
      end else begin
        ldata  = SW'($urandom);
        rdata  = SW'($urandom);
        mix    = 1'($urandom);
        exchan = 1'($urandom);
        exp_q.push_back(ref_frame(ldata, rdata, mix, exchan));
      end

      if (f == RST_F) begin
        // Hit reset around bit_cnt 20 of the frame in flight.
        repeat (20 * FALL + 5 - d1 - d2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midframe_reset_outputs",
              {27'd0, aud_bclk, aud_daclrck, aud_dacdat, frame_strobe, aud_xck}, 32'd0);
        rst = 1'b0;
        measure_release();
      end else begin
        wait_strobe();
      end
    end

    repeat (3 * BH) @(posedge clk);
    #1;
    check("frames_checked", frames_done, NF - 2);
    check("exp_queue_empty", exp_q.size(), 0);
    check("xck_behaviour", xck_err, 0);
    finish_run();
  end

endmodule
